avalon_aes_responder: RTL and testbench
=======================================

Name: avalon_aes_responder

Overview:
- Avalon-MM slave register file that answers Nios II read/write transfers for the AES peripheral inside lab9_soc.
- Holds the 128-bit key, the encrypted message and the decrypted message, plus START/DONE control registers.
- Drives a start/done handshake to an external AES decryption core and captures its 128-bit result.
- Exposes a 32-bit export conduit for board display (hex LEDs).

Parameters:
- NUM_REGS, 16, number of 32-bit registers; address width is fixed at 4 bits.
- EXPORT_SEL, 0, selects the export source: 0 = {key[0][31:16], key[3][15:0]}, 1 = {msg_de[0][31:16], msg_de[3][15:0]}.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- avs_read  in  1  Avalon read strobe
- avs_write  in  1  Avalon write strobe
- avs_chipselect  in  1  Avalon chip select
- avs_address  in  4  word address
- avs_byteenable  in  4  byte lanes for writes
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, registered
- avs_readdatavalid  out  1  high exactly 1 cycle after an accepted read
- aes_start  out  1  single-cycle start pulse to the AES core
- aes_done  in  1  core completion pulse or level
- aes_key  out  128  {reg0, reg1, reg2, reg3}
- aes_msg_enc  out  128  {reg4, reg5, reg6, reg7}
- aes_msg_dec  in  128  core result
- export_data  out  32  conduit output, selected by EXPORT_SEL

Behaviour:
- Clock and reset: one clock, clk_clk. reset_reset_n is asynchronous and active-low.
- Reset values:
  - All registers 0.
  - avs_readdata 0; avs_readdatavalid 0; aes_start 0.
  - FSM in IDLE; export_data 0.
- Register map:
  - 0-3 KEY, read/write.
  - 4-7 MSG_EN, read/write.
  - 8-11 MSG_DE, read-only from the bus; loaded only by the FSM.
  - 12-13 reserved: read 0, writes ignored.
  - 14 START: bit0 read/write.
  - 15 DONE: bit0 read-only; writes ignored.
- Writes:
  - Accepted when chipselect & write.
  - Each byte lane is updated only where its byteenable bit is 1.
  - Zero-wait: no waitrequest.
- Reads:
  - Accepted when chipselect & read.
  - avs_readdata is registered; avs_readdatavalid is high the following cycle.
  - When chipselect & read & write are all high, the write takes precedence and no read is issued.
- FSM states: IDLE, LAUNCH, WAIT, CAPTURE.
  - IDLE -> LAUNCH when START bit0 is seen 0->1 (rising edge of the register bit). DONE is cleared on this transition.
  - LAUNCH: aes_start = 1 for exactly one cycle, then go to WAIT.
  - WAIT: stay until aes_done = 1, then go to CAPTURE.
  - CAPTURE: load MSG_DE regs 8-11 from aes_msg_dec[127:96]..[31:0], set DONE = 1, go to IDLE.
- Writes during a run:
  - KEY/MSG_EN writes in LAUNCH/WAIT are accepted, but aes_key/aes_msg_enc are latched at LAUNCH and stay stable until CAPTURE.
  - START written 0 mid-run does not abort the run.
  - START re-asserted while busy is ignored; a new run needs START 0 then 1 after returning to IDLE.
- aes_done already high in the LAUNCH cycle is ignored; it is sampled only in WAIT.
- Simultaneous CAPTURE and a bus read of MSG_DE or DONE returns the pre-update value.
- Reset mid-run returns to IDLE immediately; the AES core is expected to be reset by the same reset.

Optional Feature:
- Macro: AES_IRQ_EN.
- When defined:
  - Adds output avs_irq (1 bit).
  - Set in CAPTURE; cleared by any write to address 15 or by reset.
  - Register 13 bit0 = IRQ mask (read/write, reset 0); avs_irq = pending & mask.
- When undefined: no avs_irq port; register 13 reads 0.

Decomposition:
- Package aes_regs_pkg holds:
  - Register address constants (ADDR_KEY0..ADDR_DONE).
  - FSM state enum type.
  - Export select constants.
- One sub-module, aes_byte_reg: a 32-bit register with byte-enable write and asynchronous active-low reset, instantiated per writable register.
- The FSM and readback mux stay in the top module.

Test Plan:
- Reset: assert reset_reset_n = 0 mid-operation with writes active -> all reads return 0, aes_start = 0, FSM IDLE, export_data = 0.
- Byte enables: write 0xDEADBEEF to addr 0 with byteenable 4'b0101, then read addr 0 -> 0x00AD00EF returned with readdatavalid exactly 1 cycle later.
- Full run:
  - Stimulus: key 0x000102..0F, MSG_EN loaded, START written 1; core model asserts aes_done after 11 cycles returning 0x00112233_44556677_8899AABB_CCDDEEFF.
  - Response: exactly one aes_start pulse; DONE = 1; regs 8-11 read 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF.
- Read-only registers: write addr 8 and addr 15 -> values unchanged; reserved addr 12 reads 0.
- Mid-run activity:
  - Stimulus: rewrite key and write START=1 again during WAIT.
  - Response: aes_key unchanged, no second aes_start; a new run starts only after START 0 then 1.
- AES_IRQ_EN:
  - Stimulus: mask = 1, run to completion, then write addr 15.
  - Response: avs_irq asserted on the cycle after CAPTURE; deasserted after the write to addr 15.
  - With mask = 0: avs_irq stays 0.

Source files
------------

// File: rtl/aes_regs_pkg.sv
// ============================================================================
// Module   : aes_regs_pkg
// Purpose  : Register map, FSM state type and export selectors shared by the
//            AES Avalon-MM responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_regs_pkg;

    localparam logic [3:0] ADDR_KEY0     = 4'd0;
    localparam logic [3:0] ADDR_KEY1     = 4'd1;
    localparam logic [3:0] ADDR_KEY2     = 4'd2;
    localparam logic [3:0] ADDR_KEY3     = 4'd3;
    localparam logic [3:0] ADDR_MSG_EN0  = 4'd4;
    localparam logic [3:0] ADDR_MSG_EN1  = 4'd5;
    localparam logic [3:0] ADDR_MSG_EN2  = 4'd6;
    localparam logic [3:0] ADDR_MSG_EN3  = 4'd7;
    localparam logic [3:0] ADDR_MSG_DE0  = 4'd8;
    localparam logic [3:0] ADDR_MSG_DE1  = 4'd9;
    localparam logic [3:0] ADDR_MSG_DE2  = 4'd10;
    localparam logic [3:0] ADDR_MSG_DE3  = 4'd11;
    localparam logic [3:0] ADDR_RSVD     = 4'd12;
    localparam logic [3:0] ADDR_IRQ_MASK = 4'd13;
    localparam logic [3:0] ADDR_START    = 4'd14;
    localparam logic [3:0] ADDR_DONE     = 4'd15;

    localparam int EXPORT_KEY    = 0;
    localparam int EXPORT_MSG_DE = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } aes_state_e;

endpackage

`default_nettype wire

// File: rtl/aes_byte_reg.sv
// ============================================================================
// Module   : aes_byte_reg
// Purpose  : 32-bit register with per-byte write enables, async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_byte_reg (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] q_o
);

    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] lane_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                lane_q <= 8'h00;
            end else if (we_i && be_i[b]) begin
                lane_q <= wdata_i[8*b +: 8];
            end
        end

        assign q_o[8*b +: 8] = lane_q;
    end

endmodule

`default_nettype wire

// File: rtl/avalon_aes_responder.sv
// ============================================================================
// Module   : avalon_aes_responder
// Purpose  : Avalon-MM register file and start/done sequencer for an external
//            AES decryption core. Optional IRQ: define AES_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module avalon_aes_responder
    import aes_regs_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int EXPORT_SEL = EXPORT_KEY
) (
`ifdef AES_IRQ_EN
    output logic         avs_irq,
`endif
    input  logic         clk_clk,
    input  logic         reset_reset_n,
    input  logic         avs_read,
    input  logic         avs_write,
    input  logic         avs_chipselect,
    input  logic [3:0]   avs_address,
    input  logic [3:0]   avs_byteenable,
    input  logic [31:0]  avs_writedata,
    output logic [31:0]  avs_readdata,
    output logic         avs_readdatavalid,
    output logic         aes_start,
    input  logic         aes_done,
    output logic [127:0] aes_key,
    output logic [127:0] aes_msg_enc,
    input  logic [127:0] aes_msg_dec,
    output logic [31:0]  export_data
);

    logic        wr_en;
    logic        rd_en;
    logic [31:0] rw_reg [8];
    logic [31:0] msg_de_q [4];
    logic        start_q;
    logic        start_prev_q;
    logic        done_q;
    logic        launch;
    logic        capture;
    logic [127:0] key_lat_q;
    logic [127:0] msg_lat_q;
    logic [31:0]  readdata_q;
    logic         readdatavalid_q;
    logic [31:0]  rmap [NUM_REGS];
    aes_state_e   state_q;
    aes_state_e   state_d;

    // A write wins over a simultaneous read; the read is simply not issued.
    assign wr_en = avs_chipselect & avs_write;
    assign rd_en = avs_chipselect & avs_read & ~avs_write;

    for (genvar i = 0; i < 8; i++) begin : g_rw_regs
        aes_byte_reg u_reg (
            .clk_i   (clk_clk),
            .rst_ni  (reset_reset_n),
            .we_i    (wr_en && (avs_address == ADDR_KEY0 + 4'(i))),
            .be_i    (avs_byteenable),
            .wdata_i (avs_writedata),
            .q_o     (rw_reg[i])
        );
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            done_q       <= 1'b0;
            key_lat_q    <= '0;
            msg_lat_q    <= '0;
            for (int i = 0; i < 4; i++) msg_de_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_q;
            if (wr_en && avs_address == ADDR_START && avs_byteenable[0]) begin
                start_q <= avs_writedata[0];
            end
            if (launch) begin
                done_q    <= 1'b0;
                key_lat_q <= {rw_reg[0], rw_reg[1], rw_reg[2], rw_reg[3]};
                msg_lat_q <= {rw_reg[4], rw_reg[5], rw_reg[6], rw_reg[7]};
            end else if (capture) begin
                done_q      <= 1'b1;
                msg_de_q[0] <= aes_msg_dec[127:96];
                msg_de_q[1] <= aes_msg_dec[95:64];
                msg_de_q[2] <= aes_msg_dec[63:32];
                msg_de_q[3] <= aes_msg_dec[31:0];
            end
        end
    end

    // Only a START rising edge seen while idle launches; edges during a run are lost.
    always_comb begin
        state_d   = state_q;
        aes_start = 1'b0;
        launch    = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_q && !start_prev_q) begin
                    state_d = ST_LAUNCH;
                    launch  = 1'b1;
                end
            end
            ST_LAUNCH: begin
                aes_start = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (aes_done) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign aes_key     = (state_q == ST_IDLE) ? {rw_reg[0], rw_reg[1], rw_reg[2], rw_reg[3]} : key_lat_q;
    assign aes_msg_enc = (state_q == ST_IDLE) ? {rw_reg[4], rw_reg[5], rw_reg[6], rw_reg[7]} : msg_lat_q;

`ifdef AES_IRQ_EN
    logic irq_mask_q;
    logic irq_pend_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq_mask_q <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            if (capture) begin
                irq_pend_q <= 1'b1;
            end else if (wr_en && avs_address == ADDR_DONE) begin
                irq_pend_q <= 1'b0;
            end
            if (wr_en && avs_address == ADDR_IRQ_MASK && avs_byteenable[0]) begin
                irq_mask_q <= avs_writedata[0];
            end
        end
    end

    assign avs_irq = irq_pend_q & irq_mask_q;
`endif

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) rmap[i] = '0;
        for (int i = 0; i < 8; i++) rmap[ADDR_KEY0 + 4'(i)] = rw_reg[i];
        for (int i = 0; i < 4; i++) rmap[ADDR_MSG_DE0 + 4'(i)] = msg_de_q[i];
        rmap[ADDR_RSVD]  = '0;
        rmap[ADDR_START] = {31'b0, start_q};
        rmap[ADDR_DONE]  = {31'b0, done_q};
`ifdef AES_IRQ_EN
        rmap[ADDR_IRQ_MASK] = {31'b0, irq_mask_q};
`else
        rmap[ADDR_IRQ_MASK] = '0;
`endif
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            readdatavalid_q <= rd_en;
            if (rd_en) readdata_q <= rmap[avs_address];
        end
    end

    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = readdatavalid_q;

    if (EXPORT_SEL == EXPORT_MSG_DE) begin : g_export_msg_de
        assign export_data = {msg_de_q[0][31:16], msg_de_q[3][15:0]};
    end else begin : g_export_key
        assign export_data = {rw_reg[0][31:16], rw_reg[3][15:0]};
    end

endmodule

`default_nettype wire

// File: tb/tb_avalon_aes_responder.sv
// ============================================================================
// Module   : tb_avalon_aes_responder
// Purpose  : Randomized self-checking bench with a word-level register model
//            and a behavioural AES core stand-in.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_avalon_aes_responder;

    logic         clk_clk = 1'b0;
    logic         reset_reset_n = 1'b0;
    logic         avs_read = 1'b0;
    logic         avs_write = 1'b0;
    logic         avs_chipselect = 1'b0;
    logic [3:0]   avs_address = '0;
    logic [3:0]   avs_byteenable = '0;
    logic [31:0]  avs_writedata = '0;
    logic [31:0]  avs_readdata;
    logic         avs_readdatavalid;
    logic         aes_start;
    logic         aes_done = 1'b0;
    logic [127:0] aes_key;
    logic [127:0] aes_msg_enc;
    logic [127:0] aes_msg_dec = '0;
    logic [31:0]  export_data;
`ifdef AES_IRQ_EN
    logic         avs_irq;
`endif

    avalon_aes_responder dut (
`ifdef AES_IRQ_EN
        .avs_irq           (avs_irq),
`endif
        .clk_clk           (clk_clk),
        .reset_reset_n     (reset_reset_n),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_chipselect    (avs_chipselect),
        .avs_address       (avs_address),
        .avs_byteenable    (avs_byteenable),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .aes_start         (aes_start),
        .aes_done          (aes_done),
        .aes_key           (aes_key),
        .aes_msg_enc       (aes_msg_enc),
        .aes_msg_dec       (aes_msg_dec),
        .export_data       (export_data)
    );

    always #5 clk_clk = ~clk_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word-level model of what each address should read back.
    logic [31:0] mdl [16];
    logic        m_pend;

    task automatic mdl_clear();
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        m_pend = 1'b0;
    endtask

    task automatic mdl_write(input int a, input logic [31:0] d, input logic [3:0] be);
        if (a < 8) begin
            for (int b = 0; b < 4; b++) if (be[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
        end else if (a == 14) begin
            if (be[0]) mdl[14] = {31'b0, d[0]};
        end
`ifdef AES_IRQ_EN
        else if (a == 13) begin
            if (be[0]) mdl[13] = {31'b0, d[0]};
        end
`endif
        if (a == 15) m_pend = 1'b0;
    endtask

    task automatic bus_wr(input int a, input logic [31:0] d, input logic [3:0] be, input bit cs = 1'b1);
        @(negedge clk_clk);
        avs_chipselect = cs; avs_write = 1'b1; avs_read = 1'b0;
        avs_address = 4'(a); avs_writedata = d; avs_byteenable = be;
        @(negedge clk_clk);
        avs_chipselect = 1'b0; avs_write = 1'b0;
        if (cs) mdl_write(a, d, be);
    endtask

    task automatic bus_rd(input int a, output logic [31:0] d);
        @(negedge clk_clk);
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_write = 1'b0; avs_address = 4'(a);
        @(posedge clk_clk); #1;
        chk("rdvalid", avs_readdatavalid, 1'b1);
        d = avs_readdata;
        @(negedge clk_clk);
        avs_chipselect = 1'b0; avs_read = 1'b0;
        @(posedge clk_clk); #1;
        chk("rdvalid_one_cycle", avs_readdatavalid, 1'b0);
    endtask

    task automatic read_chk(input int a, input string tag);
        logic [31:0] d;
        bus_rd(a, d);
        chk(tag, d, mdl[a]);
    endtask

    // AES core stand-in: answers each start pulse after a fixed delay.
    logic [127:0] core_res = '0;
    logic [127:0] key_at_start = '0;
    logic [127:0] msg_at_start = '0;
    int           n_starts = 0;

    initial begin
        forever begin
            @(negedge clk_clk);
            if (aes_start === 1'b1 && reset_reset_n) begin
                n_starts++;
                key_at_start = aes_key;
                msg_at_start = aes_msg_enc;
                @(negedge clk_clk);
                chk("start_width", aes_start, 1'b0);
                repeat (10) @(negedge clk_clk);
                aes_msg_dec = core_res;
                aes_done = 1'b1;
                @(negedge clk_clk);
                aes_done = 1'b0;
            end
        end
    end

    task automatic wait_start(input int s0);
        for (int k = 0; k < 10 && n_starts == s0; k++) @(negedge clk_clk);
        chk("start_seen", n_starts, s0 + 1);
    endtask

    task automatic wait_done(input logic [127:0] res);
        logic [31:0] d = '0;
        for (int k = 0; k < 30; k++) begin
            bus_rd(15, d);
            if (d[0]) break;
        end
        chk("done_set", d, 32'd1);
        mdl[15] = 32'd1;
        mdl[8] = res[127:96]; mdl[9] = res[95:64]; mdl[10] = res[63:32]; mdl[11] = res[31:0];
        m_pend = 1'b1;
    endtask

    task automatic do_run(input logic [127:0] res);
        int s0;
        core_res = res;
        s0 = n_starts;
        if (mdl[14][0]) bus_wr(14, 32'd0, 4'h1);
        bus_wr(14, 32'd1, 4'h1);
        wait_start(s0);
        chk("run_key", key_at_start, {mdl[0], mdl[1], mdl[2], mdl[3]});
        chk("run_msg", msg_at_start, {mdl[4], mdl[5], mdl[6], mdl[7]});
        wait_done(res);
        chk("run_one_start", n_starts, s0 + 1);
        for (int i = 8; i < 12; i++) read_chk(i, "msg_de");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int s0;
        mdl_clear();
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;

        chk("rst_start", aes_start, 1'b0);
        chk("rst_export", export_data, 32'd0);
        for (int i = 0; i < 16; i++) read_chk(i, "rst_read");

        bus_wr(0, 32'hDEADBEEF, 4'b0101);
        bus_rd(0, d);
        chk("byteen", d, 32'h00AD00EF);
        chk("byteen_model", d, mdl[0]);

        // Write and read together: only the write happens.
        @(negedge clk_clk);
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_write = 1'b1;
        avs_address = 4'd4; avs_writedata = 32'h12345678; avs_byteenable = 4'hF;
        @(posedge clk_clk); #1;
        chk("rw_no_read", avs_readdatavalid, 1'b0);
        @(negedge clk_clk);
        avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
        mdl_write(4, 32'h12345678, 4'hF);
        read_chk(4, "rw_write_won");

        for (int it = 0; it < 150; it++) begin
            int a;
            a = $urandom_range(0, 15);
            if ($urandom_range(0, 2) == 0) begin
                read_chk(a, "rand_read");
            end else begin
                if (a == 14) a = 13;
                bus_wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 7) != 0);
            end
            if (it % 10 == 0) chk("export", export_data, {mdl[0][31:16], mdl[3][15:0]});
        end

        bus_wr(0, 32'h00010203, 4'hF);
        bus_wr(1, 32'h04050607, 4'hF);
        bus_wr(2, 32'h08090A0B, 4'hF);
        bus_wr(3, 32'h0C0D0E0F, 4'hF);
        for (int i = 4; i < 8; i++) bus_wr(i, $urandom, 4'hF);
        do_run(128'h00112233_44556677_8899AABB_CCDDEEFF);
        read_chk(8, "full_de0");
        chk("full_de0_abs", mdl[8], 32'h00112233);
        read_chk(15, "full_done");
        chk("export_key", export_data, 32'h00010E0F);

        bus_wr(8, $urandom, 4'hF);
        bus_wr(15, $urandom, 4'hF);
        bus_wr(12, $urandom, 4'hF);
        read_chk(8, "ro_de0");
        read_chk(15, "ro_done");
        read_chk(12, "rsvd");

        // Mid-run activity: key rewrite and START toggle during WAIT.
        s0 = n_starts;
        core_res = {$urandom, $urandom, $urandom, $urandom};
        bus_wr(14, 32'd0, 4'h1);
        bus_wr(14, 32'd1, 4'h1);
        wait_start(s0);
        bus_wr(0, $urandom, 4'hF);
        bus_wr(14, 32'd0, 4'h1);
        bus_wr(14, 32'd1, 4'h1);
        chk("midrun_key_stable", aes_key, key_at_start);
        wait_done(core_res);
        repeat (8) @(negedge clk_clk);
        chk("midrun_no_restart", n_starts, s0 + 1);
        read_chk(14, "midrun_start_reg");
        do_run({$urandom, $urandom, $urandom, $urandom});

`ifdef AES_IRQ_EN
        bus_wr(13, 32'd1, 4'h1);
        do_run({$urandom, $urandom, $urandom, $urandom});
        chk("irq_set", avs_irq, 1'b1);
        bus_wr(15, $urandom, 4'hF);
        chk("irq_clear", avs_irq, 1'b0);
        bus_wr(13, 32'd0, 4'h1);
        read_chk(13, "irq_mask_rd");
        do_run({$urandom, $urandom, $urandom, $urandom});
        chk("irq_masked", avs_irq, 1'b0);
`endif

        // Reset mid-run with a write on the bus.
        s0 = n_starts;
        core_res = {$urandom, $urandom, $urandom, $urandom};
        bus_wr(14, 32'd0, 4'h1);
        bus_wr(14, 32'd1, 4'h1);
        wait_start(s0);
        @(negedge clk_clk);
        avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = 4'd1;
        avs_writedata = 32'hCAFEF00D; avs_byteenable = 4'hF;
        reset_reset_n = 1'b0;
        #1;
        mdl_clear();
        chk("mrst_start", aes_start, 1'b0);
        chk("mrst_export", export_data, 32'd0);
        chk("mrst_key", aes_key, 128'd0);
        chk("mrst_rdvalid", avs_readdatavalid, 1'b0);
        @(negedge clk_clk);
        avs_chipselect = 1'b0; avs_write = 1'b0;
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (20) @(negedge clk_clk);
        chk("mrst_no_start", n_starts, s0 + 1);
        for (int i = 0; i < 16; i++) read_chk(i, "mrst_read");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
